// File: rtl/serial_subtractor_pkg.sv
// Shared types for the digit-serial subtractor: FSM state encoding and the NZCV flag bundle.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    // Digit counter width; a single-digit operation still needs one counter bit.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational ripple-borrow subtractor for one DIGIT-bit slice: {bout, d} = a - b - bin.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] d_o,
    output logic             bout_o
);

    logic borrow;

    always_comb begin
        borrow = bin_i;
        d_o    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d_o[i] = a_i[i] ^ b_i[i] ^ borrow;
            // Borrow propagates when a<b at this bit, or when equal and a borrow arrives.
            borrow = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow);
        end
        bout_o = borrow;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor with NZCV flags and valid/ready handshakes on both sides.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_subtractor: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    sub_state_t       state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             borrow_q,  borrow_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             z_acc_q,   z_acc_d;
    logic             a_msb_q,   a_msb_d;
    logic             b_msb_q,   b_msb_d;

    logic [DIGIT-1:0] dig_diff;
    logic             dig_bout;
    alu_flags_t       flags;

    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i    (a_sh_q[DIGIT-1:0]),
        .b_i    (b_sh_q[DIGIT-1:0]),
        .bin_i  (borrow_q),
        .d_o    (dig_diff),
        .bout_o (dig_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            z_acc_q   <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
            z_acc_q   <= z_acc_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        z_acc_d   = z_acc_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                    z_acc_d  = 1'b1;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Result digits enter at the MSB end so the LSB digit lands at bit 0 after NDIG steps.
                a_sh_d    = a_sh_q >> DIGIT;
                b_sh_d    = b_sh_q >> DIGIT;
                diff_sh_d = (diff_sh_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
                borrow_d  = dig_bout;
                z_acc_d   = z_acc_q & (dig_diff == '0);
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Result outputs read zero outside DONE, so reset and idle both present a clean bus.
    always_comb begin
        flags.n = diff_sh_q[WIDTH-1];
        flags.z = z_acc_q;
        flags.c = ~borrow_q;
        flags.v = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_sh_q[WIDTH-1]);
        if (!out_valid) begin
            flags = '0;
        end
    end

    assign diff       = out_valid ? diff_sh_q : '0;
    assign borrow_out = out_valid & borrow_q;
    assign flag_n     = flags.n;
    assign flag_z     = flags.z;
    assign flag_c     = flags.c;
    assign flag_v     = flags.v;

endmodule
